// File: rtl/tabla_perf_monitor.sv
// Run-phase performance monitor: sequences READ -> PROCESS -> WRITE -> DONE and
// keeps saturating per-phase cycle counters and summed AXI lane beat counters.
`timescale 1ns/1ps
`ifndef NUM_AXI
`define NUM_AXI 4
`endif

module tabla_perf_monitor #(
  parameter int PERF_CNTR_WIDTH = 10,
  parameter int NUM_AXI         = `NUM_AXI
) (
  input  logic                       ACLK,
  input  logic                       ARESETN,
  input  logic                       compute_start,
  input  logic                       rd_done,
  input  logic                       processing_done,
  input  logic                       wr_done,
  input  logic [NUM_AXI-1:0]         rd_beat,
  input  logic [NUM_AXI-1:0]         wr_beat,
  input  logic                       perf_clear,
  output logic                       busy,
  output logic                       perf_valid,
  output logic [1:0]                 phase,
  output logic [PERF_CNTR_WIDTH-1:0] total_cycles,
  output logic [PERF_CNTR_WIDTH-1:0] rd_cycles,
  output logic [PERF_CNTR_WIDTH-1:0] pr_cycles,
  output logic [PERF_CNTR_WIDTH-1:0] wr_cycles,
  output logic [PERF_CNTR_WIDTH-1:0] rd_beats,
  output logic [PERF_CNTR_WIDTH-1:0] wr_beats
);

  localparam int W   = PERF_CNTR_WIDTH;
  localparam int PCW = $clog2(NUM_AXI + 1);

  // Low two state bits double as the phase code; bit 2 marks DONE.
  localparam logic [2:0] S_IDLE  = 3'b000;
  localparam logic [2:0] S_READ  = 3'b001;
  localparam logic [2:0] S_PROC  = 3'b010;
  localparam logic [2:0] S_WRITE = 3'b011;
  localparam logic [2:0] S_DONE  = 3'b100;

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  function automatic logic [PCW-1:0] popcount(input logic [NUM_AXI-1:0] v);
    logic [PCW-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < NUM_AXI; i++) begin
      cnt = cnt + PCW'(v[i]);
    end
    return cnt;
  endfunction

  function automatic logic [W-1:0] sat_add(input logic [W-1:0] a, input logic [PCW-1:0] b);
    logic [W:0] bx;
    logic [W:0] s;
    bx          = '0;
    bx[PCW-1:0] = b;
    s           = {1'b0, a} + bx;
    if (s[W]) begin
      return {W{1'b1}};
    end else begin
      return s[W-1:0];
    end
  endfunction

  function automatic logic [W-1:0] sat_inc(input logic [W-1:0] a);
    if (a == {W{1'b1}}) begin
      return a;
    end else begin
      return a + ONE;
    end
  endfunction

  logic [2:0]   state_q, state_d;
  logic         clear_s, busy_s;
  logic [W-1:0] tot_q, tot_d, rc_q, rc_d, pc_q, pc_d, wc_q, wc_d, rb_q, rb_d, wb_q, wb_d;

  assign busy_s = |state_q[1:0];

  // Phase sequencing; done pulses for other phases and starts while busy fall through.
  always_comb begin
    state_d = state_q;
    clear_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (compute_start) begin
          state_d = S_READ;
          clear_s = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_READ: begin
        if (rd_done) state_d = S_PROC;
        else         state_d = S_READ;
      end
      S_PROC: begin
        if (processing_done) state_d = S_WRITE;
        else                 state_d = S_PROC;
      end
      S_WRITE: begin
        if (wr_done) state_d = S_DONE;
        else         state_d = S_WRITE;
      end
      S_DONE: begin
        if (compute_start) begin
          state_d = S_READ;
          clear_s = 1'b1;
        end else if (perf_clear) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Counter next-state: cleared on run start, advanced only while busy, held otherwise.
  always_comb begin
    tot_d = tot_q;
    rc_d  = rc_q;
    pc_d  = pc_q;
    wc_d  = wc_q;
    rb_d  = rb_q;
    wb_d  = wb_q;
    if (clear_s) begin
      tot_d = '0;
      rc_d  = '0;
      pc_d  = '0;
      wc_d  = '0;
      rb_d  = '0;
      wb_d  = '0;
    end else if (busy_s) begin
      tot_d = sat_inc(tot_q);
      rb_d  = sat_add(rb_q, popcount(rd_beat));
      wb_d  = sat_add(wb_q, popcount(wr_beat));
      case (state_q)
        S_READ:  rc_d = sat_inc(rc_q);
        S_PROC:  pc_d = sat_inc(pc_q);
        S_WRITE: wc_d = sat_inc(wc_q);
        default: rc_d = rc_q;
      endcase
    end else begin
      tot_d = tot_q;
    end
  end

  // State and counter registers.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q <= S_IDLE;
      tot_q   <= '0;
      rc_q    <= '0;
      pc_q    <= '0;
      wc_q    <= '0;
      rb_q    <= '0;
      wb_q    <= '0;
    end else begin
      state_q <= state_d;
      tot_q   <= tot_d;
      rc_q    <= rc_d;
      pc_q    <= pc_d;
      wc_q    <= wc_d;
      rb_q    <= rb_d;
      wb_q    <= wb_d;
    end
  end

  assign busy         = busy_s;
  assign perf_valid   = state_q[2];
  assign phase        = state_q[1:0];
  assign total_cycles = tot_q;
  assign rd_cycles    = rc_q;
  assign pr_cycles    = pc_q;
  assign wr_cycles    = wc_q;
  assign rd_beats     = rb_q;
  assign wr_beats     = wb_q;

endmodule

// File: tb/tb_tabla_perf_monitor.sv
// Scoreboarded bench for tabla_perf_monitor: a 10-bit instance for run results
// and a 4-bit instance sharing the same stimulus for saturation.
`timescale 1ns/1ps

module tb_tabla_perf_monitor;

  typedef struct packed {
    logic [9:0] tot;
    logic [9:0] rc;
    logic [9:0] pc;
    logic [9:0] wc;
    logic [9:0] rb;
    logic [9:0] wb;
  } res_t;

  logic       ACLK = 1'b0;
  logic       ARESETN;
  logic       compute_start, rd_done, processing_done, wr_done, perf_clear;
  logic [3:0] rd_beat, wr_beat;

  logic       busy, perf_valid;
  logic [1:0] phase;
  logic [9:0] total_cycles, rd_cycles, pr_cycles, wr_cycles, rd_beats, wr_beats;

  logic       n_busy, n_valid;
  logic [1:0] n_phase;
  logic [3:0] n_tot, n_rc, n_pc, n_wc, n_rb, n_wb;

  res_t       exp_q[$];
  res_t       exp_r;
  res_t       obs;
  logic [23:0] n_obs;
  int         n_chk  = 0;
  int         n_pass = 0;

  assign obs   = {total_cycles, rd_cycles, pr_cycles, wr_cycles, rd_beats, wr_beats};
  assign n_obs = {n_tot, n_rc, n_pc, n_wc, n_rb, n_wb};

  always #5 ACLK = ~ACLK;

  tabla_perf_monitor #(.PERF_CNTR_WIDTH(10), .NUM_AXI(4)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .compute_start(compute_start), .rd_done(rd_done),
    .processing_done(processing_done), .wr_done(wr_done), .rd_beat(rd_beat), .wr_beat(wr_beat),
    .perf_clear(perf_clear), .busy(busy), .perf_valid(perf_valid), .phase(phase),
    .total_cycles(total_cycles), .rd_cycles(rd_cycles), .pr_cycles(pr_cycles),
    .wr_cycles(wr_cycles), .rd_beats(rd_beats), .wr_beats(wr_beats)
  );

  tabla_perf_monitor #(.PERF_CNTR_WIDTH(4), .NUM_AXI(4)) dut_narrow (
    .ACLK(ACLK), .ARESETN(ARESETN), .compute_start(compute_start), .rd_done(rd_done),
    .processing_done(processing_done), .wr_done(wr_done), .rd_beat(rd_beat), .wr_beat(wr_beat),
    .perf_clear(perf_clear), .busy(n_busy), .perf_valid(n_valid), .phase(n_phase),
    .total_cycles(n_tot), .rd_cycles(n_rc), .pr_cycles(n_pc),
    .wr_cycles(n_wc), .rd_beats(n_rb), .wr_beats(n_wb)
  );

  function automatic res_t mk(input int tot, rc, pc, wc, rb, wb);
    res_t r;
    r.tot = tot[9:0];
    r.rc  = rc[9:0];
    r.pc  = pc[9:0];
    r.wc  = wc[9:0];
    r.rb  = rb[9:0];
    r.wb  = wb[9:0];
    return r;
  endfunction

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic start();
    compute_start = 1'b1;
    tick();
    compute_start = 1'b0;
  endtask

  // sel: 0 none, 1 rd_done, 2 processing_done, 3 wr_done on the last of n cycles
  task automatic drive_phase(input int sel, input int n, input logic [3:0] rb, input logic [3:0] wb);
    for (int i = 0; i < n; i++) begin
      rd_beat = rb;
      wr_beat = wb;
      if (i == n - 1) begin
        case (sel)
          1: rd_done = 1'b1;
          2: processing_done = 1'b1;
          3: wr_done = 1'b1;
          default: ;
        endcase
      end
      tick();
      rd_done = 1'b0; processing_done = 1'b0; wr_done = 1'b0;
      rd_beat = 4'b0000; wr_beat = 4'b0000;
    end
  endtask

  task automatic test_reset();
    ARESETN = 1'b0;
    compute_start = 1'b0; rd_done = 1'b0; processing_done = 1'b0; wr_done = 1'b0;
    perf_clear = 1'b0; rd_beat = 4'b0000; wr_beat = 4'b0000;
    tick(); tick();
    n_chk++; if (phase !== 2'd0) $display("FAIL reset_phase: got %0d expected 0", phase); else n_pass++;
    n_chk++; if (busy !== 1'b0 || perf_valid !== 1'b0) $display("FAIL reset_flags: busy=%b valid=%b expected 0 0", busy, perf_valid); else n_pass++;
    n_chk++; if (obs !== '0) $display("FAIL reset_counters: got %h expected 0", obs); else n_pass++;
    @(negedge ACLK); ARESETN = 1'b1;
    tick(); tick();
    n_chk++; if (phase !== 2'd0) $display("FAIL idle_after_reset: phase %0d expected 0", phase); else n_pass++;
  endtask

  task automatic test_basic();
    exp_q.push_back(mk(15, 5, 7, 3, 0, 0));
    start();
    n_chk++; if (phase !== 2'd1 || busy !== 1'b1) $display("FAIL basic_read: phase %0d busy %b expected 1 1", phase, busy); else n_pass++;
    drive_phase(1, 5, 4'b0000, 4'b0000);
    n_chk++; if (phase !== 2'd2 || rd_cycles !== 10'd5) $display("FAIL basic_process: phase %0d rd_cycles %0d expected 2 5", phase, rd_cycles); else n_pass++;
    drive_phase(2, 7, 4'b0000, 4'b0000);
    n_chk++; if (phase !== 2'd3) $display("FAIL basic_write: phase %0d expected 3", phase); else n_pass++;
    drive_phase(3, 3, 4'b0000, 4'b0000);
    n_chk++; if (perf_valid !== 1'b1 || busy !== 1'b0 || phase !== 2'd0) $display("FAIL basic_done: valid %b busy %b phase %0d expected 1 0 0", perf_valid, busy, phase); else n_pass++;
    exp_r = exp_q.pop_front();
    n_chk++; if (obs !== exp_r) $display("FAIL basic_result: got %h expected %h", obs, exp_r); else n_pass++;
    tick(); tick();
    n_chk++; if (obs !== exp_r) $display("FAIL basic_hold: got %h expected %h", obs, exp_r); else n_pass++;
  endtask

  task automatic test_back_to_back();
    exp_q.push_back(mk(9, 2, 3, 4, 0, 0));
    start();
    n_chk++; if (phase !== 2'd1 || obs !== '0) $display("FAIL b2b_restart: phase %0d counters %h expected 1 0", phase, obs); else n_pass++;
    drive_phase(1, 2, 4'b0000, 4'b0000);
    drive_phase(2, 3, 4'b0000, 4'b0000);
    drive_phase(3, 4, 4'b0000, 4'b0000);
    exp_r = exp_q.pop_front();
    n_chk++; if (obs !== exp_r || perf_valid !== 1'b1) $display("FAIL b2b_result: got %h valid %b expected %h 1", obs, perf_valid, exp_r); else n_pass++;
  endtask

  task automatic test_beats();
    exp_q.push_back(mk(8, 4, 2, 2, 14, 4));
    start();
    drive_phase(0, 3, 4'b1111, 4'b0000);
    drive_phase(1, 1, 4'b0101, 4'b0000);
    drive_phase(2, 2, 4'b0000, 4'b0000);
    drive_phase(0, 1, 4'b0000, 4'b0011);
    drive_phase(3, 1, 4'b0000, 4'b0011);
    exp_r = exp_q.pop_front();
    n_chk++; if (obs !== exp_r) $display("FAIL beats_result: got %h expected %h", obs, exp_r); else n_pass++;
    // beats offered in DONE must not be counted
    drive_phase(0, 3, 4'b1111, 4'b1111);
    n_chk++; if (obs !== exp_r) $display("FAIL beats_done_ignored: got %h expected %h", obs, exp_r); else n_pass++;
  endtask

  task automatic test_saturation();
    exp_q.push_back(mk(26, 5, 20, 1, 20, 0));
    start();
    drive_phase(1, 5, 4'b1111, 4'b0000);
    n_chk++; if (n_rb !== 4'd15) $display("FAIL sat_rd_beats: got %0d expected 15", n_rb); else n_pass++;
    drive_phase(2, 20, 4'b0000, 4'b0000);
    n_chk++; if (n_pc !== 4'd15 || n_tot !== 4'd15) $display("FAIL sat_cycles: pr %0d total %0d expected 15 15", n_pc, n_tot); else n_pass++;
    drive_phase(3, 1, 4'b0000, 4'b0000);
    n_chk++; if (n_obs !== {4'd15, 4'd5, 4'd15, 4'd1, 4'd15, 4'd0}) $display("FAIL sat_narrow_result: got %h expected f5f1f0", n_obs); else n_pass++;
    exp_r = exp_q.pop_front();
    n_chk++; if (obs !== exp_r) $display("FAIL sat_wide_result: got %h expected %h", obs, exp_r); else n_pass++;
  endtask

  task automatic test_out_of_order();
    exp_q.push_back(mk(6, 2, 3, 1, 0, 0));
    start();
    processing_done = 1'b1; wr_done = 1'b1;
    tick();
    processing_done = 1'b0; wr_done = 1'b0;
    n_chk++; if (phase !== 2'd1) $display("FAIL ooo_stay_read: phase %0d expected 1", phase); else n_pass++;
    rd_done = 1'b1; processing_done = 1'b1;
    tick();
    rd_done = 1'b0; processing_done = 1'b0;
    n_chk++; if (phase !== 2'd2) $display("FAIL ooo_simul_done: phase %0d expected 2", phase); else n_pass++;
    start();
    n_chk++; if (phase !== 2'd2 || rd_cycles !== 10'd2 || pr_cycles !== 10'd1) $display("FAIL ooo_restart_ignored: phase %0d rd %0d pr %0d expected 2 2 1", phase, rd_cycles, pr_cycles); else n_pass++;
    perf_clear = 1'b1;
    tick();
    perf_clear = 1'b0;
    n_chk++; if (phase !== 2'd2 || pr_cycles !== 10'd2) $display("FAIL ooo_clear_ignored: phase %0d pr %0d expected 2 2", phase, pr_cycles); else n_pass++;
    drive_phase(2, 1, 4'b0000, 4'b0000);
    drive_phase(3, 1, 4'b0000, 4'b0000);
    exp_r = exp_q.pop_front();
    n_chk++; if (obs !== exp_r) $display("FAIL ooo_result: got %h expected %h", obs, exp_r); else n_pass++;
  endtask

  task automatic test_done_handling();
    exp_r = mk(6, 2, 3, 1, 0, 0);
    perf_clear = 1'b1;
    tick();
    perf_clear = 1'b0;
    n_chk++; if (phase !== 2'd0 || perf_valid !== 1'b0 || busy !== 1'b0) $display("FAIL done_clear_idle: phase %0d valid %b busy %b expected 0 0 0", phase, perf_valid, busy); else n_pass++;
    n_chk++; if (obs !== exp_r) $display("FAIL done_clear_hold: got %h expected %h", obs, exp_r); else n_pass++;
    exp_q.push_back(mk(3, 1, 1, 1, 1, 0));
    start();
    drive_phase(1, 1, 4'b1000, 4'b0000);
    drive_phase(2, 1, 4'b0000, 4'b0000);
    drive_phase(3, 1, 4'b0000, 4'b0000);
    exp_r = exp_q.pop_front();
    n_chk++; if (obs !== exp_r) $display("FAIL done_rerun: got %h expected %h", obs, exp_r); else n_pass++;
    compute_start = 1'b1; perf_clear = 1'b1;
    tick();
    compute_start = 1'b0; perf_clear = 1'b0;
    n_chk++; if (phase !== 2'd1 || obs !== '0) $display("FAIL done_start_wins: phase %0d counters %h expected 1 0", phase, obs); else n_pass++;
  endtask

  task automatic test_async_reset_mid_run();
    // enters already in READ from the start/clear collision
    drive_phase(1, 1, 4'b0000, 4'b0000);
    drive_phase(2, 1, 4'b0000, 4'b0000);
    drive_phase(0, 2, 4'b0000, 4'b0000);
    n_chk++; if (phase !== 2'd3 || wr_cycles !== 10'd2) $display("FAIL rst_pre_write: phase %0d wr %0d expected 3 2", phase, wr_cycles); else n_pass++;
    @(negedge ACLK);
    ARESETN = 1'b0;
    #1;
    n_chk++; if (phase !== 2'd0 || busy !== 1'b0 || obs !== '0) $display("FAIL rst_async: phase %0d busy %b counters %h expected 0 0 0", phase, busy, obs); else n_pass++;
    @(posedge ACLK);
    @(negedge ACLK);
    ARESETN = 1'b1;
    drive_phase(3, 3, 4'b1111, 4'b1111);
    n_chk++; if (phase !== 2'd0 || perf_valid !== 1'b0 || obs !== '0) $display("FAIL rst_stay_idle: phase %0d valid %b counters %h expected 0 0 0", phase, perf_valid, obs); else n_pass++;
    exp_q.push_back(mk(3, 1, 1, 1, 0, 2));
    start();
    drive_phase(1, 1, 4'b0000, 4'b0000);
    drive_phase(2, 1, 4'b0000, 4'b0000);
    drive_phase(3, 1, 4'b0000, 4'b0110);
    exp_r = exp_q.pop_front();
    n_chk++; if (obs !== exp_r || perf_valid !== 1'b1) $display("FAIL rst_resume: got %h valid %b expected %h 1", obs, perf_valid, exp_r); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_beats();
    test_saturation();
    test_out_of_order();
    test_done_handling();
    test_async_reset_mid_run();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
